// File: rtl/num24_pkg.sv
// Shared Num24 definitions: UART transmit FSM states and board-level constants.
// NUM24_UART_PARITY_EN adds the PARITY state to the transmit FSM encoding.
package num24_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int NUM24_CLK_HZ   = 100_000_000;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef NUM24_UART_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } uart_tx_state_t;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/num24_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
// Push when full and pop when empty are ignored.
module num24_sync_fifo
   import num24_pkg::*;
#(
   parameter int WIDTH = UART_DATA_BITS,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage has no reset; only written on an accepted push.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/num24_uart_tx.sv
// Num24 UART transmitter: 4-entry byte FIFO feeding an 8N1 serialiser.
// Define NUM24_UART_PARITY_EN for 8E1 frames (even parity before stop).
module num24_uart_tx
   import num24_pkg::*;
#(
   parameter int CLK_HZ     = NUM24_CLK_HZ,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_LOAD = CW'(DIV - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   // Handshake: a byte moves when tx_valid && tx_ready on a rising edge;
   // tx_ready depends only on registered state, never on tx_valid.
   logic                      ready_en;
   logic                      fifo_push;
   logic                      fifo_pop;
   logic [UART_DATA_BITS-1:0] fifo_rdata;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [AW:0]               fifo_count;

   uart_tx_state_t            state, state_d;
   logic [CW-1:0]             baud_cnt, baud_d;
   logic [2:0]                bit_idx, bit_d;
   logic [UART_DATA_BITS-1:0] sh, sh_d;
   logic                      tx_q, tx_d;
   logic                      bit_done;
`ifdef NUM24_UART_PARITY_EN
   logic                      par_q, par_d;
`endif

   assign tx_ready  = ready_en && !fifo_full;
   assign fifo_push = tx_valid && tx_ready;
   assign busy      = (state != TX_IDLE) || (fifo_count != '0);
   assign tx        = tx_q;
   assign bit_done  = (baud_cnt == '0);

   num24_sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (tx_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Holds tx_ready low through reset and releases it on the first edge after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         sh       <= '0;
         tx_q     <= 1'b1;
`ifdef NUM24_UART_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state    <= state_d;
         baud_cnt <= baud_d;
         bit_idx  <= bit_d;
         sh       <= sh_d;
         tx_q     <= tx_d;
`ifdef NUM24_UART_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   // tx_d is the line level for the next cycle, so tx changes exactly on
   // the edge that enters a new bit.
   always_comb begin
      state_d  = state;
      baud_d   = baud_cnt;
      bit_d    = bit_idx;
      sh_d     = sh;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
`ifdef NUM24_UART_PARITY_EN
      par_d    = par_q;
`endif
      case (state)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sh_d     = fifo_rdata;
               bit_d    = '0;
               baud_d   = BAUD_LOAD;
               tx_d     = 1'b0;
               state_d  = TX_START;
`ifdef NUM24_UART_PARITY_EN
               par_d    = even_parity(fifo_rdata);
`endif
            end
         end
         TX_START: begin
            if (bit_done) begin
               baud_d  = BAUD_LOAD;
               tx_d    = sh[0];
               state_d = TX_DATA;
            end else begin
               baud_d = baud_cnt - CW'(1);
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               baud_d = BAUD_LOAD;
               sh_d   = {1'b0, sh[UART_DATA_BITS-1:1]};
               bit_d  = bit_idx + 3'd1;
               if (bit_idx == LAST_BIT) begin
`ifdef NUM24_UART_PARITY_EN
                  tx_d    = par_q;
                  state_d = TX_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = TX_STOP;
`endif
               end else begin
                  tx_d = sh[1];
               end
            end else begin
               baud_d = baud_cnt - CW'(1);
            end
         end
`ifdef NUM24_UART_PARITY_EN
         TX_PARITY: begin
            if (bit_done) begin
               baud_d  = BAUD_LOAD;
               tx_d    = 1'b1;
               state_d = TX_STOP;
            end else begin
               baud_d = baud_cnt - CW'(1);
            end
         end
`endif
         TX_STOP: begin
            if (bit_done) begin
               // Chain straight into the next start bit when data is waiting.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  sh_d     = fifo_rdata;
                  bit_d    = '0;
                  baud_d   = BAUD_LOAD;
                  tx_d     = 1'b0;
                  state_d  = TX_START;
`ifdef NUM24_UART_PARITY_EN
                  par_d    = even_parity(fifo_rdata);
`endif
               end else begin
                  tx_d    = 1'b1;
                  state_d = TX_IDLE;
               end
            end else begin
               baud_d = baud_cnt - CW'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = TX_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_num24_uart_tx.sv
// Self-checking bench for num24_uart_tx at CLK_HZ=160, BAUD=10 (DIV=16).
// Frames on tx are decoded and compared against a queue of accepted bytes.
module tb_num24_uart_tx;

   localparam int CLK_HZ = 160;
   localparam int BAUD   = 10;
   localparam int DIV    = CLK_HZ / BAUD;
`ifdef NUM24_UART_PARITY_EN
   localparam int FRAME  = 11 * DIV;
`else
   localparam int FRAME  = 10 * DIV;
`endif
   localparam int LIMIT  = 3000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         mon_last_start = 0;
   int         frames_seen = 0;
   bit         mon_en = 1'b0;
   int         push_cyc = 0;
   int         fall_cyc = 0;

   num24_uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Drivers: called and returning at posedge+1
   task automatic push_byte(input logic [7:0] b);
      int w = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (!tx_ready && w < LIMIT) begin
         @(posedge clk); #1;
         w++;
      end
      if (!tx_ready) begin
         check_eq("push_timeout", 32'(tx_ready), 32'd1);
      end else begin
         exp_q.push_back(b);
         push_cyc = cyc;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      tx_valid = 1'b0;
      tx_data  = 'x;
   endtask

   task automatic wait_not_busy();
      int w = 0;
      while (busy && w < LIMIT) begin
         @(posedge clk); #1;
         w++;
      end
      check_eq("busy_timeout", 32'(busy), 32'd0);
      fall_cyc = cyc;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard monitor: decodes each frame sample-by-sample at negedges
   initial begin
      logic [7:0] cur;
      int good;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
            mon_last_start = cyc;
            start_q.push_back(cyc);
            frames_seen++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_frame", 32'd1, 32'd0);
               cur = 8'h00;
            end else begin
               cur = exp_q.pop_front();
            end
            good = 1;
            repeat (DIV - 1) begin
               @(negedge clk);
               if (tx === 1'b0) good++;
            end
            check_eq("start_bit", 32'(good), 32'(DIV));
            for (int i = 0; i < 8; i++) begin
               good = 0;
               repeat (DIV) begin
                  @(negedge clk);
                  if (tx === cur[i]) good++;
               end
               check_eq($sformatf("data_%02h_bit%0d", cur, i), 32'(good), 32'(DIV));
            end
`ifdef NUM24_UART_PARITY_EN
            good = 0;
            repeat (DIV) begin
               @(negedge clk);
               if (tx === ^cur) good++;
            end
            check_eq($sformatf("parity_%02h", cur), 32'(good), 32'(DIV));
`endif
            good = 0;
            repeat (DIV) begin
               @(negedge clk);
               if (tx === 1'b1) good++;
            end
            check_eq("stop_bit", 32'(good), 32'(DIV));
         end
      end
   end

   initial begin
      int high;
      int first;
      // Reset and idle
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(tx_ready), 32'd0);
      rst_n = 1'b1;
      cycles(1);
      check_eq("ready_after_rst", 32'(tx_ready), 32'd1);
      check_eq("busy_after_rst", 32'(busy), 32'd0);
      high = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx === 1'b1) high++;
      end
      check_eq("idle_high_100", 32'(high), 32'd100);
      mon_en = 1'b1;
      cycles(1);

      // Single byte 0x35
      push_byte(8'h35);
      idle_inputs();
      check_eq("busy_rise", 32'(busy), 32'd1);
      wait_not_busy();
      check_eq("single_frames", 32'(frames_seen), 32'd1);
      check_eq("start_latency", 32'(mon_last_start - push_cyc), 32'd2);
      check_eq("busy_fall", 32'(fall_cyc - mon_last_start), 32'(FRAME));
      cycles(5);

      // Burst 0x30..0x35 with tx_valid held high
      start_q.delete();
      frames_seen = 0;
      for (int i = 0; i < 6; i++) begin
         push_byte(8'h30 + 8'(i));
         if (i == 3) check_eq("burst_ready_after4", 32'(tx_ready), 32'd1);
         if (i == 4) check_eq("burst_ready_after5", 32'(tx_ready), 32'd0);
      end
      idle_inputs();
      wait_not_busy();
      check_eq("burst_frames", 32'(frames_seen), 32'd6);
      if (start_q.size() == 6) begin
         first = start_q[0];
         for (int k = 1; k < 6; k++) begin
            check_eq($sformatf("burst_gap%0d", k), 32'(start_q[k] - first), 32'(k * FRAME));
         end
         check_eq("burst_total", 32'(fall_cyc - first), 32'(6 * FRAME));
      end else begin
         check_eq("burst_start_count", 32'(start_q.size()), 32'd6);
      end
      cycles(5);

`ifdef NUM24_UART_PARITY_EN
      // Parity frames: 0x07 (parity 1), 0x03 (parity 0)
      push_byte(8'h07);
      idle_inputs();
      wait_not_busy();
      check_eq("parity_frame_len", 32'(fall_cyc - mon_last_start), 32'd176);
      cycles(3);
      push_byte(8'h03);
      idle_inputs();
      wait_not_busy();
      cycles(3);
`endif

      // Reset in the 4th data bit of 0xAA with two more bytes queued
      mon_en = 1'b0;
      push_byte(8'hAA);
      push_byte(8'h11);
      push_byte(8'h22);
      idle_inputs();
      first = push_cyc - 2 + 2;
      while (cyc < first + DIV + 3 * DIV + 5) begin
         @(posedge clk); #1;
      end
      check_eq("mid_busy_before", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_tx", 32'(tx), 32'd1);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_ready", 32'(tx_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(2);
      check_eq("post_rst_ready", 32'(tx_ready), 32'd1);
      check_eq("post_rst_empty", 32'(busy), 32'd0);
      high = 0;
      repeat (400) begin
         @(negedge clk);
         if (tx === 1'b1) high++;
      end
      check_eq("no_resume", 32'(high), 32'd400);

      // Reset during a start bit: tx must rise asynchronously
      @(posedge clk); #1;
      push_byte(8'h55);
      idle_inputs();
      cycles(5);
      check_eq("start_bit_low", 32'(tx), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("start_rst_tx", 32'(tx), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      cycles(2);

      // Recovery frame after reset
      mon_en = 1'b1;
      frames_seen = 0;
      push_byte(8'hC3);
      idle_inputs();
      wait_not_busy();
      check_eq("recover_frames", 32'(frames_seen), 32'd1);
      check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
      cycles(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
